// File: rtl/out_checker_pkg.sv
// -----------------------------------------------------------------------------
// out_checker_pkg
// Shared definitions for the out-channel checker:
//   checkerState_t              - FSM state encoding (IDLE, CHECK, DONE)
//   DefaultMemoryElementWidth   - default width of one out-channel word
// -----------------------------------------------------------------------------
package out_checker_pkg;

    localparam int DefaultMemoryElementWidth = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } checkerState_t;

endpackage

// File: rtl/out_checker_if.sv
// -----------------------------------------------------------------------------
// out_checker_if
// Bundles the checker's table-load, run-control, out-channel and result signals.
//   master modport : the environment (loads table, starts runs, sends words)
//   slave modport  : the checker itself
// Signals:
//   exp_we/exp_addr/exp_data  expected-table write port
//   start/exp_count           run start pulse and number of expected words
//   in_valid/in_data/in_ready out-channel handshake (transfer on valid && ready)
//   finished/success/mismatch_index/timed_out  run result
// -----------------------------------------------------------------------------
interface out_checker_if
    import out_checker_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultMemoryElementWidth,
    parameter int NExpected          = 16
);
    localparam int AddrW = $clog2(NExpected);
    localparam int IdxW  = AddrW + 1;

    logic                          exp_we;
    logic [AddrW-1:0]              exp_addr;
    logic [MemoryElementWidth-1:0] exp_data;
    logic                          start;
    logic [IdxW-1:0]               exp_count;
    logic                          in_valid;
    logic [MemoryElementWidth-1:0] in_data;
    logic                          in_ready;
    logic                          finished;
    logic                          success;
    logic [IdxW-1:0]               mismatch_index;
    logic                          timed_out;

    modport master (
        output exp_we, exp_addr, exp_data, start, exp_count, in_valid, in_data,
        input  in_ready, finished, success, mismatch_index, timed_out
    );

    modport slave (
        input  exp_we, exp_addr, exp_data, start, exp_count, in_valid, in_data,
        output in_ready, finished, success, mismatch_index, timed_out
    );

endinterface

// File: rtl/out_checker_table.sv
// -----------------------------------------------------------------------------
// out_checker_table
// Expected-value table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded table survives a reset.
// Ports:
//   clock      - write clock
//   we         - write enable (already gated by the checker's state)
//   writeAddr  - write address
//   writeData  - value written
//   readAddr   - combinational read address
//   readData   - table[readAddr]
// -----------------------------------------------------------------------------
module out_checker_table
    import out_checker_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultMemoryElementWidth,
    parameter int NExpected          = 16
) (
    input  logic                              clock,
    input  logic                              we,
    input  logic [$clog2(NExpected)-1:0]      writeAddr,
    input  logic [MemoryElementWidth-1:0]     writeData,
    input  logic [$clog2(NExpected)-1:0]      readAddr,
    output logic [MemoryElementWidth-1:0]     readData
);

    logic [MemoryElementWidth-1:0] mem [NExpected];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/out_checker.sv
// -----------------------------------------------------------------------------
// out_checker
// Compares a stream of out-channel words against a preloaded expected table.
// A run starts with a one-cycle start pulse (exp_count sampled then), accepts
// words in CHECK, and reports in DONE. Words arriving in DONE are extra and
// clear success. Table writes are only honoured outside CHECK.
//
// Optional build macro: OUT_CHECKER_TIMEOUT_EN
//   defined   - watchdog ends a run after TimeoutCycles idle CHECK cycles
//   undefined - no watchdog, timed_out tied low, CHECK waits indefinitely
//
// Ports:
//   clock  - single clock, all state on rising edge
//   reset  - asynchronous active-high reset
//   bus    - out_checker_if.slave (table load, run control, stream, results)
// -----------------------------------------------------------------------------
module out_checker
    import out_checker_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultMemoryElementWidth,
    parameter int NExpected          = 16,
    parameter int TimeoutCycles      = 1024
) (
    input  logic        clock,
    input  logic        reset,
    out_checker_if.slave bus
);

    localparam int AddrW = $clog2(NExpected);
    localparam int IdxW  = AddrW + 1;
    localparam logic [IdxW-1:0] NoMismatch = '1;
    localparam logic [IdxW-1:0] MaxCount   = IdxW'(NExpected);

    checkerState_t                 stateReg;
    logic [IdxW-1:0]               countReg;
    logic [IdxW-1:0]               indexReg;
    logic [IdxW-1:0]               mismatchIndexReg;
    logic                          failReg;
    logic                          finishedReg;
    logic                          successReg;
    logic                          inReadyReg;

    logic [MemoryElementWidth-1:0] expectedWord;
    logic                          tableWe;
    logic                          accepted;
    logic                          wordMismatch;
    logic [IdxW-1:0]               indexNext;
    logic                          lastWord;
    logic [IdxW-1:0]               clampedCount;
    logic                          startAccepted;

    assign tableWe = bus.exp_we && (stateReg != CHECK);

    out_checker_table #(
        .MemoryElementWidth (MemoryElementWidth),
        .NExpected          (NExpected)
    ) uTable (
        .clock     (clock),
        .we        (tableWe),
        .writeAddr (bus.exp_addr),
        .writeData (bus.exp_data),
        .readAddr  (indexReg[AddrW-1:0]),
        .readData  (expectedWord)
    );

    assign accepted      = bus.in_valid && inReadyReg;
    assign wordMismatch  = (bus.in_data != expectedWord);
    assign indexNext     = indexReg + IdxW'(1);
    assign lastWord      = (indexNext == countReg);
    assign clampedCount  = (bus.exp_count > MaxCount) ? MaxCount : bus.exp_count;
    assign startAccepted = bus.start && (stateReg != CHECK);

`ifdef OUT_CHECKER_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0] watchdogReg;
    logic           timedOutReg;

    assign bus.timed_out = timedOutReg;
`else
    assign bus.timed_out = 1'b0;

    // TimeoutCycles only matters in the watchdog build; still reject nonsense.
    if (TimeoutCycles < 1) begin : gBadTimeoutCycles
        $error("out_checker: TimeoutCycles must be at least 1");
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg         <= IDLE;
            countReg         <= '0;
            indexReg         <= '0;
            mismatchIndexReg <= NoMismatch;
            failReg          <= 1'b0;
            finishedReg      <= 1'b0;
            successReg       <= 1'b0;
            inReadyReg       <= 1'b0;
`ifdef OUT_CHECKER_TIMEOUT_EN
            watchdogReg      <= '0;
            timedOutReg      <= 1'b0;
`endif
        end else if (startAccepted) begin
            // A start in DONE wins over a simultaneous word: the word is dropped.
            stateReg         <= CHECK;
            countReg         <= clampedCount;
            indexReg         <= '0;
            mismatchIndexReg <= NoMismatch;
            failReg          <= 1'b0;
            finishedReg      <= 1'b0;
            successReg       <= 1'b0;
            inReadyReg       <= 1'b1;
`ifdef OUT_CHECKER_TIMEOUT_EN
            watchdogReg      <= '0;
            timedOutReg      <= 1'b0;
`endif
        end else begin
            case (stateReg)
                CHECK: begin
                    if (countReg == '0) begin
                        // Empty run: done at once; a word seen now is already extra.
                        stateReg    <= DONE;
                        finishedReg <= 1'b1;
                        successReg  <= !accepted;
                    end else if (accepted) begin
                        indexReg <= indexNext;
                        if (wordMismatch && !failReg) begin
                            failReg          <= 1'b1;
                            mismatchIndexReg <= indexReg;
                        end
                        if (lastWord) begin
                            stateReg    <= DONE;
                            finishedReg <= 1'b1;
                            successReg  <= !(failReg || wordMismatch);
                        end
                    end
`ifdef OUT_CHECKER_TIMEOUT_EN
                    if (accepted) begin
                        watchdogReg <= '0;
                    end else if (watchdogReg == WdLast) begin
                        stateReg    <= DONE;
                        finishedReg <= 1'b1;
                        successReg  <= 1'b0;
                        timedOutReg <= 1'b1;
                    end else begin
                        watchdogReg <= watchdogReg + WdW'(1);
                    end
`endif
                end
                DONE: begin
                    // Anything after the last expected word is an extra output.
                    if (accepted) begin
                        successReg <= 1'b0;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready       = inReadyReg;
    assign bus.finished       = finishedReg;
    assign bus.success        = successReg;
    assign bus.mismatch_index = mismatchIndexReg;

endmodule
